// File: rtl/fetch_target_queue_if.sv
// rtl/fetch_target_queue_if.sv - predictor/fetch/commit bundle for fetch_target_queue
interface fetch_target_queue_if #(
    parameter int PTR_W  = 3,
    parameter int PRED_W = 64
);
    logic                flush_i;
    logic                bpu_valid_i;
    logic                bpu_ready_o;
    logic [31:0]         bpu_pc_i;
    logic [1:0]          bpu_mask_i;
    logic [2*PRED_W-1:0] bpu_pred_i;
    logic                ic_valid_o;
    logic                ic_ready_i;
    logic [31:0]         ic_pc_o;
    logic [1:0]          ic_mask_o;
    logic [PTR_W-1:0]    ic_id_o;
    logic                commit_i;
    logic [PTR_W-1:0]    rd_id_i;
    logic [31:0]         rd_pc_o;
    logic [2*PRED_W-1:0] rd_pred_o;
    logic [PTR_W:0]      count_o;

    modport master (
        output flush_i, bpu_valid_i, bpu_pc_i, bpu_mask_i, bpu_pred_i,
               ic_ready_i, commit_i, rd_id_i,
        input  bpu_ready_o, ic_valid_o, ic_pc_o, ic_mask_o, ic_id_o,
               rd_pc_o, rd_pred_o, count_o
    );

    modport slave (
        input  flush_i, bpu_valid_i, bpu_pc_i, bpu_mask_i, bpu_pred_i,
               ic_ready_i, commit_i, rd_id_i,
        output bpu_ready_o, ic_valid_o, ic_pc_o, ic_mask_o, ic_id_o,
               rd_pc_o, rd_pred_o, count_o
    );
endinterface

// File: rtl/fetch_target_queue.sv
// rtl/fetch_target_queue.sv - in-order fetch target queue between predictor and ICache
module fetch_target_queue #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int PRED_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_target_queue_if.slave q
);
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]         pc_mem   [DEPTH];
    logic [1:0]          mask_mem [DEPTH];
    logic [2*PRED_W-1:0] pred_mem [DEPTH];

    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] issue_q, issue_d;
    logic [PTR_W:0] tail_q, tail_d;
    logic [PTR_W:0] count;
    logic           full;
    logic           enq;
    logic           iss;
    logic           cmt;

    // Wrap bit in the MSB makes tail - head the true occupancy even when indices alias.
    assign count = tail_q - head_q;
    assign full  = (count == FULL_CNT);

    assign q.bpu_ready_o = rst_n & ~q.flush_i & ~full;
    assign q.ic_valid_o  = rst_n & ~q.flush_i & (issue_q != tail_q);

    assign enq = q.bpu_valid_i & q.bpu_ready_o;
    assign iss = q.ic_valid_o & q.ic_ready_i;
    assign cmt = q.commit_i & (head_q != issue_q) & ~q.flush_i;

    always_comb begin
        head_d  = head_q;
        issue_d = issue_q;
        tail_d  = tail_q;
        if (q.flush_i) begin
            head_d  = '0;
            issue_d = '0;
            tail_d  = '0;
        end else begin
            if (enq) tail_d  = tail_q + PTR_ONE;
            if (iss) issue_d = issue_q + PTR_ONE;
            if (cmt) head_d  = head_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            issue_q <= '0;
            tail_q  <= '0;
        end else begin
            head_q  <= head_d;
            issue_q <= issue_d;
            tail_q  <= tail_d;
        end
    end

    // Payload storage is left unreset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail_q[PTR_W-1:0]]   <= q.bpu_pc_i;
            mask_mem[tail_q[PTR_W-1:0]] <= q.bpu_mask_i;
            pred_mem[tail_q[PTR_W-1:0]] <= q.bpu_pred_i;
        end
    end

    assign q.ic_pc_o   = pc_mem[issue_q[PTR_W-1:0]];
    assign q.ic_mask_o = mask_mem[issue_q[PTR_W-1:0]];
    assign q.ic_id_o   = issue_q[PTR_W-1:0];

    assign q.rd_pc_o   = pc_mem[q.rd_id_i];
    assign q.rd_pred_o = pred_mem[q.rd_id_i];
    assign q.count_o   = count;
endmodule

// File: tb/tb_fetch_target_queue.sv
// tb/tb_fetch_target_queue.sv - directed scoreboard bench for fetch_target_queue
module tb_fetch_target_queue;
    typedef struct {
        logic [31:0] pc;
        logic [1:0]  mask;
        logic [2:0]  id;
    } ent_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ent_t         sb[$];
    logic [31:0]  pc_m   [8];
    logic [127:0] pred_m [8];
    int           m_cnt;
    int           m_iss;
    logic [2:0]   m_tid;

    fetch_target_queue_if #(.PTR_W(3), .PRED_W(64)) f ();

    fetch_target_queue #(.DEPTH(8), .PTR_W(3), .PRED_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge with inputs already driven; checks outputs, advances the model, steps one clock.
    task automatic cycle(output bit acc);
        bit   er;
        bit   ev;
        bit   iss;
        bit   cmt;
        ent_t e;
        #1;
        er = !f.flush_i && (m_cnt < 8);
        ev = !f.flush_i && (sb.size() > 0);
        chk("bpu_ready", 128'(f.bpu_ready_o), 128'(er));
        chk("ic_valid", 128'(f.ic_valid_o), 128'(ev));
        chk("count", 128'(f.count_o), 128'(m_cnt));
        if (ev) begin
            chk("ic_pc", 128'(f.ic_pc_o), 128'(sb[0].pc));
            chk("ic_mask", 128'(f.ic_mask_o), 128'(sb[0].mask));
            chk("ic_id", 128'(f.ic_id_o), 128'(sb[0].id));
        end
        acc = 1'b0;
        if (f.flush_i) begin
            sb.delete();
            m_cnt = 0;
            m_iss = 0;
            m_tid = 3'd0;
        end else begin
            acc = f.bpu_valid_i && er;
            iss = f.ic_ready_i && ev;
            cmt = f.commit_i && (m_iss > 0);
            if (iss) e = sb.pop_front();
            m_iss = m_iss + int'(iss) - int'(cmt);
            m_cnt = m_cnt + int'(acc) - int'(cmt);
            if (acc) begin
                e.pc   = f.bpu_pc_i;
                e.mask = f.bpu_mask_i;
                e.id   = m_tid;
                sb.push_back(e);
                pc_m[m_tid]   = f.bpu_pc_i;
                pred_m[m_tid] = f.bpu_pred_i;
                m_tid = m_tid + 3'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        bit a;
        cycle(a);
    endtask

    task automatic drive_pkt(input int k);
        f.bpu_valid_i = 1'b1;
        f.bpu_pc_i    = 32'h1c00_0000 + 32'(8 * k);
        f.bpu_mask_i  = 2'((k % 3) + 1);
        f.bpu_pred_i  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic fill(input int n);
        int k;
        bit a;
        k = 0;
        for (int i = 0; i < 4 * n && k < n; i++) begin
            drive_pkt(k);
            cycle(a);
            if (a) k++;
        end
        f.bpu_valid_i = 1'b0;
        chk("fill_accepted", 128'(f.count_o), 128'(m_cnt));
    endtask

    task automatic drain(input int budget);
        f.bpu_valid_i = 1'b0;
        f.ic_ready_i  = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (m_cnt == 0) break;
            f.commit_i = (m_iss > 0);
            tick();
        end
        f.commit_i   = 1'b0;
        f.ic_ready_i = 1'b0;
        #1;
        chk("drain_count", 128'(f.count_o), 128'(0));
    endtask

    initial begin
        bit a;
        int k;
        checks = 0;
        errors = 0;
        m_cnt  = 0;
        m_iss  = 0;
        m_tid  = 3'd0;
        rst_n         = 1'b0;
        f.flush_i     = 1'b0;
        f.bpu_valid_i = 1'b1;
        f.bpu_pc_i    = 32'h0;
        f.bpu_mask_i  = 2'b00;
        f.bpu_pred_i  = '0;
        f.ic_ready_i  = 1'b1;
        f.commit_i    = 1'b0;
        f.rd_id_i     = 3'd0;

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_bpu_ready", 128'(f.bpu_ready_o), 128'(0));
        chk("reset_ic_valid", 128'(f.ic_valid_o), 128'(0));
        @(negedge clk);
        rst_n         = 1'b1;
        f.bpu_valid_i = 1'b0;
        f.ic_ready_i  = 1'b0;
        tick();

        // Fill to full with fetch stalled; the ninth packet must be held off.
        fill(8);
        drive_pkt(8);
        tick();
        tick();
        f.bpu_valid_i = 1'b0;
        #1;
        chk("full_count", 128'(f.count_o), 128'(8));
        chk("full_head_pc", 128'(f.ic_pc_o), 128'(32'h1c00_0000));
        chk("full_head_id", 128'(f.ic_id_o), 128'(0));

        f.ic_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        f.ic_ready_i = 1'b0;
        tick();
        #1;
        chk("issued_count", 128'(f.count_o), 128'(8));

        f.rd_id_i = 3'd3;
        #1;
        chk("rd_pc3", 128'(f.rd_pc_o), 128'(32'h1c00_0018));
        chk("rd_pred3", f.rd_pred_o, pred_m[3]);
        f.rd_id_i = 3'd7;
        #1;
        chk("rd_pc7", 128'(f.rd_pc_o), 128'(32'h1c00_0038));
        drain(20);

        // Full queue sees commit and a new packet together: commit wins, enqueue waits a cycle.
        fill(8);
        f.ic_ready_i = 1'b1;
        tick();
        f.ic_ready_i = 1'b0;
        drive_pkt(40);
        f.commit_i = 1'b1;
        cycle(a);
        f.commit_i = 1'b0;
        #1;
        chk("commit_full_count", 128'(f.count_o), 128'(7));
        chk("commit_full_ready", 128'(f.bpu_ready_o), 128'(1));
        cycle(a);
        f.bpu_valid_i = 1'b0;
        #1;
        chk("reenq_count", 128'(f.count_o), 128'(8));
        drain(40);

        // Continuous streaming across the index wrap.
        k = 0;
        for (int i = 0; i < 80 && k < 20; i++) begin
            drive_pkt(100 + k);
            f.ic_ready_i = 1'b1;
            f.commit_i   = (m_iss > 0);
            cycle(a);
            if (a) k++;
        end
        drain(40);

        // Flush with five entries while a packet enqueues and one issues.
        fill(5);
        drive_pkt(200);
        f.flush_i    = 1'b1;
        f.ic_ready_i = 1'b1;
        tick();
        f.flush_i     = 1'b0;
        f.bpu_valid_i = 1'b0;
        f.ic_ready_i  = 1'b0;
        #1;
        chk("flush_count", 128'(f.count_o), 128'(0));
        chk("flush_ic_valid", 128'(f.ic_valid_o), 128'(0));
        drive_pkt(300);
        tick();
        f.bpu_valid_i = 1'b0;
        #1;
        chk("post_flush_id", 128'(f.ic_id_o), 128'(0));
        chk("post_flush_pc", 128'(f.ic_pc_o), 128'(32'h1c00_0000 + 32'(8 * 300)));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
